// File: rtl/ofswitch_stats_axi_responder.sv
`default_nettype none
// ============================================================================
// Module   : ofswitch_stats_axi_responder
// Function : Passive AXI-Stream tap counting per-port packets, bytes and
//            last-arrival time, with a 64-bit free-running timestamp, all
//            exposed through a read-only AXI4-Lite slave.
// Revision : 1.0 - initial release
// ============================================================================
module ofswitch_stats_axi_responder #(
  parameter logic [31:0] C_BASE_ADDR      = 32'hC000_0000,
  parameter logic [31:0] C_HIGH_ADDR      = 32'hCFFF_FFFF,
  parameter int          C_NUM_PORTS      = 8,
  // Reset values of the timestamp and byte counters; zero in normal use,
  // non-zero values let wrap-around behaviour be exercised quickly.
  parameter logic [63:0] C_TS_RESET       = 64'd0,
  parameter logic [31:0] C_BYTE_CNT_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic        mon_tlast,
  input  logic [2:0]  mon_tuser_in_port,
  input  logic [13:0] mon_tuser_packet_length,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        beat;
  logic        sop;
  logic [31:0] pkt_cnt   [8];
  logic [31:0] byte_cnt  [8];
  logic [31:0] last_time [8];
  logic [63:0] ts;
  logic [31:0] ts_hi_shadow;

  logic        accept;
  logic [31:0] off;
  logic        in_window;
  logic [2:0]  port_sel;
  logic [1:0]  word_sel;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        rd_ts_lo;
  logic        unused_inputs;

  assign beat      = mon_tvalid & mon_tready;
  assign accept    = s_axi_arvalid & s_axi_arready;
  assign off       = s_axi_araddr - C_BASE_ADDR;
  assign in_window = (s_axi_araddr >= C_BASE_ADDR) && (s_axi_araddr <= C_HIGH_ADDR);
  assign port_sel  = off[6:4];
  assign word_sel  = off[3:2];

  assign unused_inputs = ^{s_axi_arprot, off[1:0]};

  // Start-of-packet tracker: the beat after a tlast beat opens a new packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      sop <= 1'b1;
    end else if (beat) begin
      sop <= mon_tlast;
    end
  end

  // Per-port counters, updated on the first beat of each packet only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        pkt_cnt[i]   <= 32'd0;
        byte_cnt[i]  <= C_BYTE_CNT_RESET;
        last_time[i] <= 32'd0;
      end
    end else if (beat && sop) begin
      for (int i = 0; i < 8; i++) begin
        if ((i < C_NUM_PORTS) && (mon_tuser_in_port == 3'(i))) begin
          pkt_cnt[i]   <= pkt_cnt[i] + 32'd1;
          byte_cnt[i]  <= byte_cnt[i] + {18'd0, mon_tuser_packet_length};
          last_time[i] <= ts[31:0];
        end
      end
    end
  end

  // Free-running timestamp.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= C_TS_RESET;
    end else begin
      ts <= ts + 64'd1;
    end
  end

  // Address decode and read-data mux, evaluated against current counter values.
  always_comb begin
    rd_data  = 32'd0;
    rd_resp  = RESP_OKAY;
    rd_ts_lo = 1'b0;
    if (!in_window) begin
      rd_resp = RESP_DECERR;
    end else if (off[31:2] == 30'h0000_4004) begin
      rd_data  = ts[31:0];
      rd_ts_lo = 1'b1;
    end else if (off[31:2] == 30'h0000_4005) begin
      rd_data = ts_hi_shadow;
    end else if (!off[16] && (off[15:7] == 9'd0)) begin
      if (32'(port_sel) >= C_NUM_PORTS) begin
        rd_resp = RESP_SLVERR;
      end else begin
        case (word_sel)
          2'd0:    rd_data = pkt_cnt[port_sel];
          2'd1:    rd_data = byte_cnt[port_sel];
          2'd2:    rd_data = last_time[port_sel];
          default: rd_data = 32'd0;
        endcase
      end
    end else begin
      rd_resp = RESP_SLVERR;
    end
  end

  // Response capture at AR accept; the timestamp high word is shadowed on a
  // low-word read so a lo/hi pair reads a coherent 64-bit value.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_rdata  <= 32'd0;
      s_axi_rresp  <= RESP_OKAY;
      ts_hi_shadow <= 32'd0;
    end else if (accept) begin
      s_axi_rdata <= rd_data;
      s_axi_rresp <= rd_resp;
      if (rd_ts_lo) begin
        ts_hi_shadow <= ts[63:32];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (state)
      ST_RST: begin
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_RST;
      end
    endcase
  end

endmodule
`default_nettype wire
